// File: rtl/pe_pkg.sv
// Shared types and helpers for the multi-lane MAC processing element.
// Holds the control FSM state type and a width-parameterised saturation helper.
package pe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_OUTPUT = 2'd2
  } pe_state_t;

  localparam int SAT_MAX_W = 64;

  typedef struct packed {
    logic signed [SAT_MAX_W-1:0] value;
    logic                        clipped;
  } sat_result_t;

  // Clamp a sign-extended value into the signed range of out_w bits.
  function automatic sat_result_t saturate(input logic signed [SAT_MAX_W-1:0] value,
                                           input int unsigned                 out_w);
    logic signed [SAT_MAX_W-1:0] v_max;
    logic signed [SAT_MAX_W-1:0] v_min;
    sat_result_t                 res;
    v_max = (SAT_MAX_W'(1) <<< (out_w - 1)) - SAT_MAX_W'(1);
    v_min = -v_max - SAT_MAX_W'(1);
    if (value > v_max) begin
      res.value   = v_max;
      res.clipped = 1'b1;
    end else if (value < v_min) begin
      res.value   = v_min;
      res.clipped = 1'b1;
    end else begin
      res.value   = value;
      res.clipped = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/pe_lane_dot.sv
// Combinational per-beat dot product: sums LANES signed products of W-bit operands,
// sign-extended to the accumulator width.
module pe_lane_dot
  import pe_pkg::*;
#(
  parameter int W         = 8,
  parameter int LANES     = 4,
  parameter int ACC_WIDTH = 21
) (
  input  logic [W*LANES-1:0]          i_a_flat,
  input  logic [W*LANES-1:0]          i_b_flat,
  output logic signed [ACC_WIDTH-1:0] o_dot
);

  localparam int PW = 2 * W;

  logic signed [PW-1:0] w_prod [LANES];

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic signed [PW-1:0] w_a_ext;
    logic signed [PW-1:0] w_b_ext;
    assign w_a_ext     = PW'($signed(i_a_flat[gi*W +: W]));
    assign w_b_ext     = PW'($signed(i_b_flat[gi*W +: W]));
    assign w_prod[gi]  = w_a_ext * w_b_ext;
  end

  always_comb begin
    o_dot = '0;
    for (int i = 0; i < LANES; i++) begin
      o_dot = o_dot + ACC_WIDTH'(w_prod[i]);
    end
  end

endmodule

// File: rtl/pe_multilane_mac.sv
// Multi-lane MAC processing element: captures one operand set, accumulates LANES
// products per cycle, adds bias, optional ReLU, saturates, and holds the result until taken.
module pe_multilane_mac
  import pe_pkg::*;
#(
  parameter int VECTOR_LENGTH = 16,
  parameter int W             = 8,
  parameter int LANES         = 4,
  parameter int ACC_WIDTH     = 2*W + $clog2(VECTOR_LENGTH) + 1,
  parameter int BIAS_WIDTH    = 8,
  parameter int OUT_WIDTH     = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start_valid,
  output logic                          start_ready,
  input  logic [W*VECTOR_LENGTH-1:0]    in_vector_flat,
  input  logic [W*VECTOR_LENGTH-1:0]    weight_row_flat,
  input  logic signed [BIAS_WIDTH-1:0]  bias,
  input  logic                          relu_en,
  output logic signed [OUT_WIDTH-1:0]   result,
  output logic                          sat,
  output logic                          result_valid,
  input  logic                          result_ready,
  output logic                          busy
);

  localparam int BEATS   = VECTOR_LENGTH / LANES;
  localparam int BEAT_W  = $clog2(BEATS + 1);
  localparam int SLICE_W = W * LANES;

  pe_state_t                    r_state;
  pe_state_t                    w_state_next;
  logic [W*VECTOR_LENGTH-1:0]   r_vec;
  logic [W*VECTOR_LENGTH-1:0]   r_wgt;
  logic signed [BIAS_WIDTH-1:0] r_bias;
  logic                         r_relu;
  logic signed [ACC_WIDTH-1:0]  r_acc;
  logic [BEAT_W-1:0]            r_beat;
  logic signed [OUT_WIDTH-1:0]  r_result;
  logic                         r_sat;

  logic                         w_accept;
  logic                         w_final;
  logic [BEAT_W-1:0]            w_beat_idx;
  logic [SLICE_W-1:0]           w_vec_slice;
  logic [SLICE_W-1:0]           w_wgt_slice;
  logic signed [ACC_WIDTH-1:0]  w_lane_sum;
  logic signed [ACC_WIDTH-1:0]  w_bias_ext;
  logic signed [ACC_WIDTH-1:0]  w_biased;
  logic signed [ACC_WIDTH-1:0]  w_post_relu;
  sat_result_t                  w_sat;

  // The beat counter runs one past the last beat; that extra ACCUM cycle finalises.
  assign w_final     = (r_state == ST_ACCUM) && (r_beat == BEAT_W'(BEATS));
  assign w_beat_idx  = w_final ? '0 : r_beat;
  assign w_vec_slice = r_vec[w_beat_idx*SLICE_W +: SLICE_W];
  assign w_wgt_slice = r_wgt[w_beat_idx*SLICE_W +: SLICE_W];

  pe_lane_dot #(
    .W         (W),
    .LANES     (LANES),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_lane_dot (
    .i_a_flat (w_vec_slice),
    .i_b_flat (w_wgt_slice),
    .o_dot    (w_lane_sum)
  );

  assign w_bias_ext  = ACC_WIDTH'(r_bias);
  assign w_biased    = r_acc + w_bias_ext;
  assign w_post_relu = (r_relu && (w_biased < 0)) ? '0 : w_biased;
  assign w_sat       = saturate(SAT_MAX_W'(w_post_relu), OUT_WIDTH);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    start_ready  = 1'b0;
    busy         = 1'b0;
    result_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        start_ready = 1'b1;
        if (start_valid) w_state_next = ST_ACCUM;
      end
      ST_ACCUM: begin
        busy = 1'b1;
        if (w_final) w_state_next = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        busy         = 1'b1;
        result_valid = 1'b1;
        if (result_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_accept = start_ready && start_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vec    <= '0;
      r_wgt    <= '0;
      r_bias   <= '0;
      r_relu   <= 1'b0;
      r_acc    <= '0;
      r_beat   <= '0;
      r_result <= '0;
      r_sat    <= 1'b0;
    end else if (w_accept) begin
      r_vec  <= in_vector_flat;
      r_wgt  <= weight_row_flat;
      r_bias <= bias;
      r_relu <= relu_en;
      r_acc  <= '0;
      r_beat <= '0;
    end else if (r_state == ST_ACCUM) begin
      if (w_final) begin
        r_result <= w_sat.value[OUT_WIDTH-1:0];
        r_sat    <= w_sat.clipped;
      end else begin
        r_acc  <= r_acc + w_lane_sum;
        r_beat <= r_beat + 1'b1;
      end
    end
  end

  assign result = r_result;
  assign sat    = r_sat;

endmodule

// File: doc/pe_multilane_mac.md
PE_MULTILANE_MAC -- requirements
Module: pe_multilane_mac

Interface
REQ-001 SHALL have parameter VECTOR_LENGTH, default 16, elements per dot product.
REQ-002 SHALL have parameter W, default 8, signed element width of inputs and weights.
REQ-003 SHALL have parameter LANES, default 4, multiplies per cycle; VECTOR_LENGTH SHALL be an integer multiple of LANES.
REQ-004 SHALL have parameter ACC_WIDTH, default 2*W+$clog2(VECTOR_LENGTH)+1, signed accumulator width.
REQ-005 SHALL have parameter BIAS_WIDTH, default 8, signed bias width.
REQ-006 SHALL have parameter OUT_WIDTH, default 16, signed saturated result width.
REQ-007 clk  input  1  clock; all logic rising-edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 start_valid  input  1  operand set offered.
REQ-010 start_ready  output  1  block accepts operands; high only in IDLE.
REQ-011 in_vector_flat  input  W*VECTOR_LENGTH  signed input elements; element i at bits [i*W +: W].
REQ-012 weight_row_flat  input  W*VECTOR_LENGTH  signed weights, same packing.
REQ-013 bias  input  BIAS_WIDTH  signed bias.
REQ-014 relu_en  input  1  apply ReLU; sampled at accept.
REQ-015 result  output  OUT_WIDTH  signed saturated result.
REQ-016 sat  output  1  result was clipped; valid with result_valid.
REQ-017 result_valid  output  1  result available.
REQ-018 result_ready  input  1  consumer takes result.
REQ-019 busy  output  1  high in ACCUM or OUTPUT.

Function
REQ-020 SHALL implement FSM states IDLE, ACCUM, OUTPUT.
REQ-021 Accept = start_valid && start_ready: SHALL register in_vector_flat, weight_row_flat, bias, relu_en; clear accumulator and beat counter; go to ACCUM.
REQ-022 Operand changes after accept SHALL NOT affect the current result; start_valid outside IDLE SHALL be ignored.
REQ-023 In ACCUM each cycle SHALL add the sum of LANES sign-extended products for beat k (elements k*LANES .. k*LANES+LANES-1) into the accumulator, k = 0..VECTOR_LENGTH/LANES-1.
REQ-024 After final beat SHALL compute acc + sign-extended bias at ACC_WIDTH, apply ReLU (negative -> 0) if relu_en, saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1], register result and sat, go to OUTPUT.
REQ-025 Latency: accept at edge T -> result_valid high after edge T+VECTOR_LENGTH/LANES+1.
REQ-026 In OUTPUT result_valid SHALL stay high and result/sat stable until result_ready; on result_valid && result_ready SHALL go to IDLE (start_ready high next cycle).
REQ-027 Accumulation SHALL be exact (no wrap) for all inputs at default ACC_WIDTH; sat SHALL be 1 only when saturation changed the value.
REQ-028 LANES == VECTOR_LENGTH SHALL work (single ACCUM beat).

Reset
REQ-029 reset SHALL force IDLE, result=0, sat=0, result_valid=0, busy=0, accumulator and beat counter 0; start_ready high the cycle after reset deasserts.
REQ-030 reset mid-ACCUM or mid-OUTPUT SHALL abort the operation with no result_valid pulse.

Structure
REQ-031 Shared package pe_pkg SHALL hold the FSM state type and a saturate function parameterised by widths.
REQ-032 A combinational sub-module pe_lane_dot SHALL compute the LANES-product sum for one beat; registers stay in pe_multilane_mac.

Verification (defaults, VL=16, LANES=4)
REQ-033 All in=1, w=1, bias=3, relu_en=0, result_ready=1 -> result=19, sat=0, result_valid after 5 edges post-accept.
REQ-034 All in=-128, w=-128, bias=0 -> acc=262144, result=32767, sat=1.
REQ-035 All in=1, w=-1, bias=0: relu_en=0 -> result=-16; relu_en=1 -> result=0, sat=0.
REQ-036 result_ready low 3 cycles after result_valid -> result stable, start_ready low; new start_valid ignored; handshake then IDLE.
REQ-037 reset asserted in 2nd ACCUM beat -> no result_valid, all outputs 0; new operands (in=2,w=3,bias=-1) -> result=95.
